// File: rtl/flit_packet_assembler.sv
// Receive-side flit assembler: collects HEAD..TAIL flits into a flat packet buffer,
// presents the packet downstream and reports malformed traffic as one-cycle error pulses.
module flit_packet_assembler #(
  parameter int FLIT_W         = 32,
  parameter int MAX_FLITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FLIT_W-1:0]           in_flit,
  input  logic [1:0]                  in_type,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [FLIT_W*MAX_FLITS-1:0] out_data,
  output logic [$clog2(MAX_FLITS+1)-1:0] out_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err_valid,
  output logic [1:0]                  err_code
);
  localparam int CW = $clog2(MAX_FLITS+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  localparam logic [1:0] T_NOPE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  localparam logic [1:0] E_NONE   = 2'b00;
  localparam logic [1:0] E_ORPHAN = 2'b01;
  localparam logic [1:0] E_ABORT  = 2'b10;
  localparam logic [1:0] E_OVF    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DROP, S_HOLD} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CW-1:0]                   r_count, w_count_nxt;
  logic [TW-1:0]                   r_idle,  w_idle_nxt;
  logic [MAX_FLITS-1:0][FLIT_W-1:0] r_buf,  w_buf_nxt;
  logic [1:0]                      r_err,   w_err_nxt;
  logic                            w_acc;

  assign w_acc = in_valid & (r_state != S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_idle  <= '0;
      r_buf   <= '0;
      r_err   <= E_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idle  <= w_idle_nxt;
      r_buf   <= w_buf_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idle_nxt  = r_idle;
    w_buf_nxt   = r_buf;
    w_err_nxt   = E_NONE;
    unique case (r_state)
      S_IDLE, S_DROP: begin
        if (w_acc) begin
          if (in_type == T_HEAD) begin
            w_buf_nxt    = '0;
            w_buf_nxt[0] = in_flit;
            w_count_nxt  = CW'(1);
            w_idle_nxt   = '0;
            w_state_nxt  = S_COLLECT;
          end else if (r_state == S_IDLE && in_type != T_NOPE) begin
            w_err_nxt = E_ORPHAN;
          end else if (r_state == S_DROP && in_type == T_TAIL) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_COLLECT: begin
        if (w_acc && in_type != T_NOPE) begin
          w_idle_nxt = '0;
          if (in_type == T_HEAD) begin
            w_err_nxt    = E_ABORT;
            w_buf_nxt    = '0;
            w_buf_nxt[0] = in_flit;
            w_count_nxt  = CW'(1);
          end else if (in_type == T_BODY && r_count == CW'(MAX_FLITS-1)) begin
            // last slot is reserved for the TAIL, so a BODY here can never complete
            w_err_nxt   = E_OVF;
            w_buf_nxt   = '0;
            w_count_nxt = '0;
            w_state_nxt = S_DROP;
          end else begin
            for (int i = 0; i < MAX_FLITS; i++)
              if (CW'(i) == r_count) w_buf_nxt[i] = in_flit;
            w_count_nxt = r_count + CW'(1);
            if (in_type == T_TAIL) w_state_nxt = S_HOLD;
          end
        end else if (r_idle == TW'(TIMEOUT_CYCLES-1)) begin
          w_err_nxt   = E_OVF;
          w_buf_nxt   = '0;
          w_count_nxt = '0;
          w_idle_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_idle_nxt = r_idle + TW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_buf_nxt   = '0;
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign out_len   = out_valid ? r_count : '0;
  assign out_data  = r_buf;
  assign err_code  = r_err;
  assign err_valid = |r_err;
endmodule

// File: tb/tb_flit_packet_assembler.sv
// Directed bench for flit_packet_assembler: stimulus pushes expected packets/errors,
// negedge monitors pop and compare whatever the DUT presents.
module tb_flit_packet_assembler;
  localparam int FW = 32;
  localparam int MF = 8;
  localparam logic [1:0] NOPE = 2'b00, HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [FW-1:0]   in_flit;
  logic [1:0]      in_type;
  logic            in_valid;
  logic            in_ready;
  logic [FW*MF-1:0] out_data;
  logic [3:0]      out_len;
  logic            out_valid;
  logic            out_ready;
  logic            err_valid;
  logic [1:0]      err_code;

  flit_packet_assembler #(.FLIT_W(FW), .MAX_FLITS(MF), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_type(in_type),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_len(out_len),
    .out_valid(out_valid), .out_ready(out_ready), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] len; logic [FW*MF-1:0] data; } pkt_t;
  pkt_t       pq[$];
  logic [1:0] eq[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [3:0] len, input logic [MF-1:0][FW-1:0] d);
    pkt_t p;
    p.len = len;
    p.data = d;
    pq.push_back(p);
  endtask

  task automatic send(input logic [1:0] t, input logic [FW-1:0] d);
    int n = 0;
    in_valid = 1'b1; in_type = t; in_flit = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout type=%0d got in_ready=0 required 1", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_type = NOPE; in_flit = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_in_ready"},  256'(in_ready),  256'(1));
    chk({nm, "_out_valid"}, 256'(out_valid), 256'(0));
    chk({nm, "_out_len"},   256'(out_len),   256'(0));
    chk({nm, "_out_data"},  256'(out_data),  256'(0));
    chk({nm, "_err_valid"}, 256'(err_valid), 256'(0));
    chk({nm, "_err_code"},  256'(err_code),  256'(0));
  endtask

  // Packet and error monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_vec++;
        if (pq.size() == 0) begin
          n_bad++;
          $display("FAIL pkt_unexpected got len=%0d data=%h required none", out_len, out_data);
        end else begin
          pkt_t e;
          e = pq.pop_front();
          if (out_len !== e.len || out_data !== e.data) begin
            n_bad++;
            $display("FAIL pkt got len=%0d data=%h required len=%0d data=%h",
                     out_len, out_data, e.len, e.data);
          end
        end
      end
      if (err_valid) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_bad++;
          $display("FAIL err_unexpected got code=%0d required none", err_code);
        end else begin
          logic [1:0] ec;
          ec = eq.pop_front();
          if (err_code !== ec) begin
            n_bad++;
            $display("FAIL err_code got %0d required %0d", err_code, ec);
          end
        end
      end
    end
  end

  initial begin
    logic [MF-1:0][FW-1:0] ev;
    rst_n = 1'b0; in_valid = 1'b0; in_type = NOPE; in_flit = '0; out_ready = 1'b1;
    #12;
    chk_reset_outs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: basic 3-flit packet, latency of one cycle after TAIL
    ev = '0; ev[0] = 32'hA0; ev[1] = 32'hA1; ev[2] = 32'hA2;
    push_pkt(4'd3, ev);
    out_ready = 1'b0;
    send(HEAD, 32'hA0); send(BODY, 32'hA1);
    send(TAIL, 32'hA2);
    chk("t1_valid_after_tail", 256'(out_valid), 256'(1));
    chk("t1_len", 256'(out_len), 256'(3));
    out_ready = 1'b1;
    idle(1);
    chk("t1_idle_after_hs", 256'(out_valid), 256'(0));

    // T2: max-length packet, then overflow
    ev = '0;
    for (int i = 0; i < 8; i++) ev[i] = 32'hB0 + 32'(i);
    push_pkt(4'd8, ev);
    send(HEAD, 32'hB0);
    for (int i = 1; i < 7; i++) send(BODY, 32'hB0 + 32'(i));
    send(TAIL, 32'hB7);
    idle(2);
    eq.push_back(2'b11);
    send(HEAD, 32'hC0);
    for (int i = 1; i < 8; i++) send(BODY, 32'hC0 + 32'(i));
    send(BODY, 32'hCE); send(TAIL, 32'hCF);
    idle(2);
    chk("t2_no_valid_after_drop", 256'(out_valid), 256'(0));

    // T3: orphan, abort by new HEAD
    eq.push_back(2'b01);
    eq.push_back(2'b10);
    ev = '0; ev[0] = 32'h2; ev[1] = 32'h3;
    push_pkt(4'd2, ev);
    send(BODY, 32'h5);
    send(HEAD, 32'h1); send(HEAD, 32'h2); send(TAIL, 32'h3);
    idle(2);

    // T3b: overflow into DROP then HEAD restarts without an extra error
    eq.push_back(2'b11);
    ev = '0; ev[0] = 32'hD0; ev[1] = 32'hD1;
    push_pkt(4'd2, ev);
    send(HEAD, 32'hE0);
    for (int i = 1; i < 8; i++) send(BODY, 32'hE0 + 32'(i));
    send(HEAD, 32'hD0); send(TAIL, 32'hD1);
    idle(2);

    // T4: timeout at exactly 64 idle cycles; 63 idle is tolerated
    eq.push_back(2'b11);
    send(HEAD, 32'h44);
    idle(63);
    chk("t4_no_err_at_63", 256'(err_valid), 256'(0));
    idle(1);
    chk("t4_err_at_64", 256'(err_valid), 256'(1));
    chk("t4_err_code", 256'(err_code), 256'(3));
    idle(2);
    ev = '0; ev[0] = 32'h45; ev[1] = 32'h46;
    push_pkt(4'd2, ev);
    send(HEAD, 32'h45);
    idle(63);
    send(TAIL, 32'h46);
    idle(2);

    // T5: hold with back-pressure, HEAD stalled then accepted
    ev = '0; ev[0] = 32'h61; ev[1] = 32'h62; ev[2] = 32'h63;
    push_pkt(4'd3, ev);
    out_ready = 1'b0;
    send(HEAD, 32'h61); send(BODY, 32'h62); send(TAIL, 32'h63);
    ev = '0; ev[0] = 32'h70; ev[1] = 32'h71;
    push_pkt(4'd2, ev);
    fork
      send(HEAD, 32'h70);
      begin
        for (int i = 0; i < 10; i++) begin
          chk("t5_in_ready_low", 256'(in_ready), 256'(0));
          chk("t5_data_stable", 256'(out_data), 256'h63_00000062_00000061);
          chk("t5_len_stable", 256'(out_len), 256'(3));
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    send(TAIL, 32'h71);
    idle(2);

    // T6: asynchronous reset mid-COLLECT and mid-HOLD
    send(HEAD, 32'h91); send(BODY, 32'h92);
    #2 rst_n = 1'b0; #1;
    chk_reset_outs("t6_collect");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(HEAD, 32'h81); send(TAIL, 32'h82);
    chk("t6_hold_valid", 256'(out_valid), 256'(1));
    #2 rst_n = 1'b0; #1;
    chk_reset_outs("t6_hold");
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    ev = '0; ev[0] = 32'hF0; ev[1] = 32'hF1; ev[2] = 32'hF2;
    push_pkt(4'd3, ev);
    send(HEAD, 32'hF0); send(BODY, 32'hF1); send(TAIL, 32'hF2);
    idle(4);

    chk("pkt_queue_drained", 256'(pq.size()), 256'(0));
    chk("err_queue_drained", 256'(eq.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
